// File: rtl/ones_cksum_engine.sv
// ones_cksum_engine
// Computes the 16-bit Internet (ones'-complement) checksum over a byte range
// of the live packet-header array. A request is accepted with a one-cycle
// start_i pulse in IDLE. The engine then sums one big-endian 16-bit word per
// cycle, folds the carries twice, and returns the complemented sum with a
// one-cycle cksum_ready_o pulse. A request that runs past the end of the
// array is clamped to the array, and range_err_o is raised with the result.
module ones_cksum_engine #(
    parameter int HDR_MAX_LEN = 128,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        pkt_hdr_i [0:HDR_MAX_LEN-1],
    input  logic [ADDR_W-1:0] field_start_i,
    input  logic [LEN_W-1:0]  field_len_i,
    output logic              cksum_ready_o,
    output logic [15:0]       cksum_val_o,
    output logic              range_err_o
);

    // The byte index is never wider than the array needs. A clamped request
    // keeps every byte that is read inside the array.
    localparam int IDX_W = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;

    localparam logic [LEN_W:0]    HDR_MAX_EXT  = (LEN_W + 1)'(HDR_MAX_LEN);
    localparam logic [ADDR_W-1:0] HDR_MAX_ADDR = ADDR_W'(HDR_MAX_LEN);
    localparam logic [LEN_W-1:0]  HDR_MAX_LENW = LEN_W'(HDR_MAX_LEN);
    localparam logic [LEN_W-1:0]  TWO          = LEN_W'(2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SUM   = 2'd1;
    localparam logic [1:0] ST_FOLD1 = 2'd2;
    localparam logic [1:0] ST_FOLD2 = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [31:0]      acc;
    logic [IDX_W-1:0] addr;
    logic [LEN_W-1:0] rem;
    logic             err_flag;

    logic             start_in_range;
    logic [LEN_W-1:0] avail_len;
    logic [LEN_W-1:0] clamped_len;
    logic             overrun;

    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;
    logic             two_left;
    logic [15:0]      word;
    logic [LEN_W-1:0] rem_next;
    logic [31:0]      acc_plus_word;
    logic [16:0]      fold_sum;

    // Decode a new request: clamp its length to the array and flag overruns
    always_comb begin
        start_in_range = (field_start_i < HDR_MAX_ADDR);
        avail_len      = HDR_MAX_LENW - LEN_W'(field_start_i);
        clamped_len    = '0;
        if (start_in_range) begin
            clamped_len = (field_len_i < avail_len) ? field_len_i : avail_len;
        end
        overrun = (({1'b0, LEN_W'(field_start_i)} + {1'b0, field_len_i}) > HDR_MAX_EXT);
    end

    // Fetch the current big-endian word; an odd trailing byte is padded low
    always_comb begin
        idx_hi        = addr;
        idx_lo        = addr + IDX_W'(1);
        two_left      = (rem >= TWO);
        word          = {pkt_hdr_i[idx_hi], two_left ? pkt_hdr_i[idx_lo] : 8'h00};
        rem_next      = two_left ? (rem - TWO) : '0;
        acc_plus_word = acc + {16'h0000, word};
        fold_sum      = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    end

    // Sequence IDLE -> SUM (one word per cycle) -> FOLD1 -> FOLD2 -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = (clamped_len != '0) ? ST_SUM : ST_FOLD1;
                end
            end
            ST_SUM: begin
                if (rem_next == '0) begin
                    next_state = ST_FOLD1;
                end
            end
            ST_FOLD1: next_state = ST_FOLD2;
            ST_FOLD2: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latching, word accumulation and carry folding
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc      <= '0;
            addr     <= '0;
            rem      <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr     <= field_start_i[IDX_W-1:0];
                        rem      <= clamped_len;
                        err_flag <= overrun;
                        acc      <= '0;
                    end
                end
                ST_SUM: begin
                    acc  <= acc_plus_word;
                    addr <= addr + IDX_W'(2);
                    rem  <= rem_next;
                end
                ST_FOLD1: acc <= {15'h0000, fold_sum};
                ST_FOLD2: acc <= {15'h0000, fold_sum};
                default:  acc <= acc;
            endcase
        end
    end

    // Publish the complemented sum with a one-cycle ready pulse; results hold until the next one
    always_ff @(posedge clk) begin
        if (!rst) begin
            cksum_ready_o <= 1'b0;
            cksum_val_o   <= 16'h0000;
            range_err_o   <= 1'b0;
        end else begin
            cksum_ready_o <= (state == ST_FOLD2);
            if (state == ST_FOLD2) begin
                cksum_val_o <= ~fold_sum[15:0];
                range_err_o <= err_flag;
            end
        end
    end

endmodule

// File: tb/tb_ones_cksum_engine.sv
// Testbench for ones_cksum_engine: directed vectors plus randomized requests,
// all checked against a byte-level reference checksum model.
module tb_ones_cksum_engine;

    localparam int HDR_MAX_LEN = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  hdr [0:HDR_MAX_LEN-1];
    logic [31:0] field_start_i;
    logic [31:0] field_len_i;
    logic        cksum_ready_o;
    logic [15:0] cksum_val_o;
    logic        range_err_o;

    int checks = 0;
    int errors = 0;

    ones_cksum_engine #(
        .HDR_MAX_LEN(HDR_MAX_LEN),
        .ADDR_W(32),
        .LEN_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .pkt_hdr_i(hdr),
        .field_start_i(field_start_i),
        .field_len_i(field_len_i),
        .cksum_ready_o(cksum_ready_o),
        .cksum_val_o(cksum_val_o),
        .range_err_o(range_err_o)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: Internet checksum of the clamped byte range, computed directly on bytes
    function automatic void refModel(input int unsigned st, input int unsigned ln,
                                     output logic [15:0] val, output logic err, output int lat);
        longint unsigned stop;
        longint unsigned sum;
        int unsigned     cnt;
        logic [15:0]     w;
        stop = st;
        stop += ln;
        err  = (stop > HDR_MAX_LEN);
        if (st >= HDR_MAX_LEN) cnt = 0;
        else cnt = (ln < HDR_MAX_LEN - st) ? ln : (HDR_MAX_LEN - st);
        sum = 0;
        for (int unsigned i = 0; i < cnt; i += 2) begin
            w[15:8] = hdr[st + i];
            w[7:0]  = (i + 1 < cnt) ? hdr[st + i + 1] : 8'h00;
            sum += w;
        end
        while ((sum >> 16) != 0) sum = (sum & 64'hFFFF) + (sum >> 16);
        val = ~sum[15:0];
        lat = int'((cnt + 1) / 2) + 3;
    endfunction

    // Issue one request at the current falling edge and wait for its result.
    // Returns in the ready cycle (falling edge), so a caller may chain a new request.
    task automatic applyStimulus(input string tag, input int unsigned st, input int unsigned ln, input bit poke_busy);
        logic [15:0] exp_val;
        logic        exp_err;
        int          exp_lat;
        int          cyc;
        refModel(st, ln, exp_val, exp_err, exp_lat);
        start_i       = 1'b1;
        field_start_i = st;
        field_len_i   = ln;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        cyc     = 1;
        while (!cksum_ready_o && cyc < 400) begin
            if (poke_busy && cyc == 2) begin
                start_i       = 1'b1;
                field_start_i = 32'd0;
                field_len_i   = 32'd2;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        checkOutput({tag, "_latency"}, cyc, exp_lat);
        checkOutput({tag, "_val"}, {16'h0, cksum_val_o}, {16'h0, exp_val});
        checkOutput({tag, "_err"}, {31'h0, range_err_o}, {31'h0, exp_err});
    endtask

    // Ready must be a single-cycle pulse when no new request follows
    task automatic checkReadyDrop(input string tag);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, {31'h0, cksum_ready_o}, 32'h0);
    endtask

    task automatic randomizeHdr();
        for (int i = 0; i < HDR_MAX_LEN; i++) hdr[i] = 8'($urandom);
    endtask

    // Main sequence
    initial begin
        logic [7:0] ipv4 [0:19];
        int seen_ready;
        ipv4 = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
        rst           = 1'b0;
        start_i       = 1'b0;
        field_start_i = '0;
        field_len_i   = '0;
        for (int i = 0; i < HDR_MAX_LEN; i++) hdr[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", {31'h0, cksum_ready_o}, 32'h0);
        checkOutput("reset_val", {16'h0, cksum_val_o}, 32'h0);
        checkOutput("reset_err", {31'h0, range_err_o}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) hdr[14 + i] = ipv4[i];
        applyStimulus("ipv4", 14, 20, 1'b0);
        checkOutput("ipv4_known", {16'h0, cksum_val_o}, 32'hB861);
        checkReadyDrop("ipv4");

        hdr[40] = 8'h01; hdr[41] = 8'h02; hdr[42] = 8'h03;
        applyStimulus("odd", 40, 3, 1'b0);
        checkOutput("odd_known", {16'h0, cksum_val_o}, 32'hFBFD);
        checkReadyDrop("odd");

        for (int i = 60; i < 64; i++) hdr[i] = 8'hFF;
        applyStimulus("carry", 60, 4, 1'b0);
        checkOutput("carry_known", {16'h0, cksum_val_o}, 32'h0000);
        checkReadyDrop("carry");

        applyStimulus("zero", 10, 0, 1'b0);
        checkOutput("zero_known", {16'h0, cksum_val_o}, 32'hFFFF);
        checkReadyDrop("zero");

        hdr[126] = 8'h12; hdr[127] = 8'h34;
        applyStimulus("overrun", 126, 4, 1'b0);
        checkOutput("overrun_known", {31'h0, range_err_o}, 32'h1);
        checkReadyDrop("overrun");

        applyStimulus("far_start", 200, 5, 1'b0);
        checkReadyDrop("far_start");
        applyStimulus("huge_len", 0, 32'hFFFF_FFFF, 1'b0);
        checkReadyDrop("huge_len");

        applyStimulus("busy", 14, 20, 1'b1);
        checkOutput("busy_known", {16'h0, cksum_val_o}, 32'hB861);
        checkReadyDrop("busy");

        applyStimulus("b2b_a", 40, 3, 1'b0);
        applyStimulus("b2b_b", 14, 20, 1'b0);
        checkReadyDrop("b2b_b");

        // Abort a request mid-SUM with reset
        randomizeHdr();
        start_i = 1'b1; field_start_i = 0; field_len_i = 60;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("abort_ready", {31'h0, cksum_ready_o}, 32'h0);
        checkOutput("abort_val", {16'h0, cksum_val_o}, 32'h0);
        checkOutput("abort_err", {31'h0, range_err_o}, 32'h0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        seen_ready = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (cksum_ready_o) seen_ready++;
        end
        checkOutput("abort_no_ready", seen_ready, 32'h0);
        applyStimulus("after_reset", 0, 60, 1'b0);
        checkReadyDrop("after_reset");

        // Randomized requests, sometimes chained back-to-back in the ready cycle
        for (int n = 0; n < 40; n++) begin
            randomizeHdr();
            applyStimulus($sformatf("rand%0d", n), $urandom_range(0, 140), $urandom_range(0, 140), 1'b0);
            if ($urandom_range(0, 3) != 0) checkReadyDrop($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
